// File: rtl/mc_datapath_if.sv
// Shared instruction/data memory port with a req/ack handshake.
// The core drives the request side; the memory acknowledges when the
// access completes and, for reads, presents the data in the same cycle.
interface mc_datapath_if #(
  parameter int ADDR_BITS = 12
);
  logic                 mem_req;
  logic                 mem_we;
  logic [ADDR_BITS-1:0] mem_addr;
  logic [31:0]          mem_wdata;
  logic [31:0]          mem_rdata;
  logic                 mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/mc_datapath.sv
// Multi-cycle MIPS subset core: datapath and control FSM in one block.
// Fetch and data accesses share one memory port; any number of wait
// states is tolerated. Illegal opcodes and misaligned lw/sw trap to HALT.
module mc_datapath #(
  parameter logic [31:0] RESET_PC  = 32'h0000_3000,
  parameter int          ADDR_BITS = 12
) (
  input  logic          clk,
  input  logic          reset,
  mc_datapath_if.master bus,
  output logic          halted,
  output logic [31:0]   pc_out,
  output logic [2:0]    dbg_state
);

  typedef enum logic [2:0] {
    S_RST    = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  state_t      state, state_next;
  logic [31:0] pc, ir, a, b, alu_out, mdr;
  logic [31:0] regs [32];

  // Instruction fields, always taken from the latched IR.
  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm;
  logic [25:0] target;

  assign op     = ir[31:26];
  assign rs     = ir[25:21];
  assign rt     = ir[20:16];
  assign rd     = ir[15:11];
  assign shamt  = ir[10:6];
  assign funct  = ir[5:0];
  assign imm    = ir[15:0];
  assign target = ir[25:0];

  logic [31:0] imm_sext, imm_zext, br_offset;
  assign imm_sext  = {{16{imm[15]}}, imm};
  assign imm_zext  = {16'h0000, imm};
  assign br_offset = {{14{imm[15]}}, imm, 2'b00};

  logic is_rtype, is_addiu, is_ori, is_lui, is_lw, is_sw, is_beq, is_j;
  logic legal;

  // Classify the instruction held in IR and flag anything unsupported.
  always_comb begin
    is_rtype = (op == OP_RTYPE);
    is_addiu = (op == OP_ADDIU);
    is_ori   = (op == OP_ORI);
    is_lui   = (op == OP_LUI);
    is_lw    = (op == OP_LW);
    is_sw    = (op == OP_SW);
    is_beq   = (op == OP_BEQ);
    is_j     = (op == OP_J);
    if (is_rtype) begin
      legal = funct inside {FN_SLL, FN_ADDU, FN_SUBU, FN_AND, FN_OR, FN_SLT};
    end else begin
      legal = is_addiu | is_ori | is_lui | is_lw | is_sw | is_beq | is_j;
    end
  end

  logic [31:0] alu_result;

  // ALU: operates on the A/B operand registers latched in DECODE.
  always_comb begin
    // NOTE: assigning a default first guarantees every path drives the
    // signal, so no latch is inferred for the unlisted cases.
    alu_result = 32'h0;
    if (is_rtype) begin
      case (funct)
        FN_ADDU: alu_result = a + b;
        FN_SUBU: alu_result = a - b;
        FN_AND:  alu_result = a & b;
        FN_OR:   alu_result = a | b;
        FN_SLT:  alu_result = ($signed(a) < $signed(b)) ? 32'h1 : 32'h0;
        FN_SLL:  alu_result = b << shamt;
        default: alu_result = 32'h0;
      endcase
    end else if (is_addiu || is_lw || is_sw) begin
      alu_result = a + imm_sext;
    end else if (is_ori) begin
      alu_result = a | imm_zext;
    end else if (is_lui) begin
      alu_result = {imm, 16'h0000};
    end
  end

  logic [4:0]  wb_dst;
  logic [31:0] wb_data;
  assign wb_dst  = is_rtype ? rd : rt;
  assign wb_data = is_lw ? mdr : alu_out;

  // State register; reset returns the FSM to RST and drops mem_req at once.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values regardless of statement order.
    if (reset) state <= S_RST;
    else       state <= state_next;
  end

  // Next-state logic: memory states hold until the access is acknowledged.
  always_comb begin
    state_next = state;
    case (state)
      S_RST:    state_next = S_FETCH;
      S_FETCH:  if (bus.mem_ack) state_next = S_DECODE;
      S_DECODE: state_next = legal ? S_EXEC : S_HALT;
      S_EXEC: begin
        if (is_lw || is_sw) begin
          state_next = (alu_result[1:0] != 2'b00) ? S_HALT : S_MEM;
        end else if (is_beq || is_j) begin
          state_next = S_FETCH;
        end else begin
          state_next = S_WB;
        end
      end
      S_MEM:    if (bus.mem_ack) state_next = is_sw ? S_FETCH : S_WB;
      S_WB:     state_next = S_FETCH;
      S_HALT:   state_next = S_HALT;
      default:  state_next = S_HALT;
    endcase
  end

  // Bus outputs decoded from registers only; mem_ack never reaches them.
  always_comb begin
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = 32'h0;
    halted        = 1'b0;
    case (state)
      S_FETCH: begin
        bus.mem_req  = 1'b1;
        bus.mem_addr = pc[ADDR_BITS-1:0];
      end
      S_MEM: begin
        bus.mem_req   = 1'b1;
        bus.mem_we    = is_sw;
        bus.mem_addr  = alu_out[ADDR_BITS-1:0];
        bus.mem_wdata = b;
      end
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
  end

  assign pc_out    = pc;
  assign dbg_state = state;

  // Datapath registers and register file, updated per FSM state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc      <= RESET_PC;
      ir      <= 32'h0;
      a       <= 32'h0;
      b       <= 32'h0;
      alu_out <= 32'h0;
      mdr     <= 32'h0;
      // NOTE: the register file is reset with the core because software
      // assumes zeroed registers; this keeps it in flops, not a RAM macro.
      for (int i = 0; i < 32; i++) regs[i] <= 32'h0;
    end else begin
      case (state)
        S_FETCH: begin
          if (bus.mem_ack) begin
            ir <= bus.mem_rdata;
            pc <= pc + 32'd4;
          end
        end
        S_DECODE: begin
          a <= regs[rs];
          b <= regs[rt];
        end
        S_EXEC: begin
          alu_out <= alu_result;
          if (is_beq && (a == b)) pc <= pc + br_offset;
          if (is_j)               pc <= {pc[31:28], target, 2'b00};
        end
        S_MEM: begin
          if (bus.mem_ack && !is_sw) mdr <= bus.mem_rdata;
        end
        S_WB: begin
          // $0 is never written, so it always reads back as zero.
          if (wb_dst != 5'd0) regs[wb_dst] <= wb_data;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_datapath.sv
// Scoreboard bench for mc_datapath: directed programs with hand-computed
// store results; a memory responder with programmable wait states, and a
// monitor that pops expected writes whenever the core completes a store.
`timescale 1ns/1ps
module tb_mc_datapath;
  localparam int          ADDR_BITS = 12;
  localparam logic [31:0] RESET_PC  = 32'h0000_3000;
  localparam logic [2:0]  ST_RST = 3'd0, ST_FETCH = 3'd1, ST_MEM = 3'd4, ST_HALT = 3'd6;

  logic        clk, reset;
  logic        halted;
  logic [31:0] pc_out;
  logic [2:0]  dbg_state;

  mc_datapath_if #(.ADDR_BITS(ADDR_BITS)) bus ();

  mc_datapath #(.RESET_PC(RESET_PC), .ADDR_BITS(ADDR_BITS)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .halted(halted), .pc_out(pc_out), .dbg_state(dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Program for the zero-wait run, placed at word 16 (0x3040).
  localparam logic [31:0] P1 [0:28] = '{
    32'hAC01_0100, 32'h3C01_FFFF, 32'h3421_FFFF, 32'h2402_0001, 32'h0022_1821,
    32'h0021_0021, 32'hAC03_0104, 32'hAC00_0108, 32'h0041_2823, 32'h0022_302A,
    32'h0041_382A, 32'h0002_4100, 32'h0028_4824, 32'h0105_5025, 32'h244B_FFFD,
    32'hAC05_010C, 32'hAC06_0110, 32'hAC07_0114, 32'hAC08_0118, 32'hAC09_011C,
    32'hAC0A_0120, 32'hAC0B_0124, 32'h1022_0005, 32'hAC02_0128, 32'h1042_0002,
    32'hAC01_012C, 32'hAC01_012C, 32'hAC0B_0130, 32'h0800_0C04
  };
  // Program for the wait-state run, placed at word 16 (0x3040).
  localparam logic [31:0] P2 [0:7] = '{
    32'h3C01_A5A5, 32'h3421_5A5A, 32'hAC01_0008, 32'h8C04_0008,
    32'hAC04_0100, 32'h8C00_0008, 32'hAC00_0104, 32'hFC00_0000
  };

  logic [31:0]          mem [1024];
  int                   wait_cycles = 0;
  bit                   block_en = 1'b0;
  bit                   spurious_ack = 1'b0;
  logic [ADDR_BITS-1:0] block_addr = 12'h200;

  typedef struct {
    logic [ADDR_BITS-1:0] addr;
    logic [31:0]          data;
  } wr_t;
  wr_t exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic push_wr(input logic [ADDR_BITS-1:0] a, input logic [31:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
  endtask

  task automatic wait_state(input logic [2:0] st, input int budget, input string name);
    int n = 0;
    while (dbg_state !== st && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    check(name, 32'(dbg_state), 32'(st));
  endtask

  task automatic wait_fetch(input logic [31:0] pc, input int budget, input string name, output int at);
    int n = 0;
    while (!(dbg_state === ST_FETCH && pc_out === pc) && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    at = cyc;
    check(name, (dbg_state === ST_FETCH) ? pc_out : 32'hFFFF_FFFF, pc);
  endtask

  task automatic wait_drain(input int budget, input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  // Memory responder: acks after wait_cycles stall cycles per access.
  initial begin : responder
    int wcnt;
    wcnt = 0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (reset || !bus.mem_req) begin
        bus.mem_ack = spurious_ack;
        wcnt = 0;
      end else if (block_en && bus.mem_addr == block_addr) begin
        bus.mem_ack = 1'b0;
      end else if (wcnt >= wait_cycles) begin
        bus.mem_ack = 1'b1;
        if (bus.mem_we) mem[bus.mem_addr[ADDR_BITS-1:2]] = bus.mem_wdata;
        else            bus.mem_rdata = mem[bus.mem_addr[ADDR_BITS-1:2]];
        wcnt = 0;
      end else begin
        bus.mem_ack = 1'b0;
        wcnt++;
      end
    end
  end

  // Monitor: every completed store is matched against the expected queue.
  initial begin : monitor
    wr_t e;
    forever begin
      @(negedge clk); #1;
      if (!reset && bus.mem_req && bus.mem_ack && bus.mem_we) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL sb_spurious_write: addr %h data %h, no write expected", bus.mem_addr, bus.mem_wdata);
        end else begin
          e = exp_q.pop_front();
          check("sb_write_addr", 32'(bus.mem_addr), 32'(e.addr));
          check("sb_write_data", bus.mem_wdata, e.data);
        end
      end
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int t0, t1, t2, fetch_cnt, bad_pc, mem_seen;
    logic [ADDR_BITS-1:0] last_addr;
    reset = 1'b1;

    // Zero-wait run: ALU ops, wraparound, $0 writes, branches, loop.
    clear_mem();
    mem[0] = 32'h3401_1234;                      // ori $1,$0,0x1234
    mem[1] = 32'h0800_0C10;                      // j 0x3040
    mem[4] = 32'h1021_FFFF;                      // 0x3010: beq $1,$1,-1
    for (int i = 0; i < 29; i++) mem[16 + i] = P1[i];
    push_wr(12'h100, 32'h0000_1234);
    push_wr(12'h104, 32'h0000_0000);
    push_wr(12'h108, 32'h0000_0000);
    push_wr(12'h10C, 32'h0000_0002);
    push_wr(12'h110, 32'h0000_0001);
    push_wr(12'h114, 32'h0000_0000);
    push_wr(12'h118, 32'h0000_0010);
    push_wr(12'h11C, 32'h0000_0010);
    push_wr(12'h120, 32'h0000_0012);
    push_wr(12'h124, 32'hFFFF_FFFE);
    push_wr(12'h128, 32'h0000_0001);
    push_wr(12'h130, 32'hFFFF_FFFE);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_mem_req",   32'(bus.mem_req),   32'd0);
    check("rst_mem_we",    32'(bus.mem_we),    32'd0);
    check("rst_mem_addr",  32'(bus.mem_addr),  32'd0);
    check("rst_mem_wdata", bus.mem_wdata,      32'd0);
    check("rst_halted",    32'(halted),        32'd0);
    check("rst_pc_out",    pc_out,             RESET_PC);
    check("rst_state",     32'(dbg_state),     32'(ST_RST));
    @(negedge clk); #1;
    check("first_req",      32'(bus.mem_req),  32'd1);
    check("first_req_addr", 32'(bus.mem_addr), 32'h000);
    check("first_state",    32'(dbg_state),    32'(ST_FETCH));
    repeat (4) @(negedge clk);
    #1;
    check("ori_pc_after5",    pc_out,         32'h0000_3004);
    check("ori_state_after5", 32'(dbg_state), 32'(ST_FETCH));
    wait_drain(600, "p1_drain");
    repeat (10) @(negedge clk);
    fetch_cnt = 0;
    bad_pc    = 0;
    last_addr = '1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk); #1;
      if (dbg_state === ST_FETCH) begin
        fetch_cnt++;
        last_addr = bus.mem_addr;
        if (pc_out !== 32'h0000_3010) bad_pc++;
      end
    end
    check("loop_fetch_count", 32'(fetch_cnt), 32'd10);
    check("loop_bad_pc",      32'(bad_pc),    32'd0);
    check("loop_fetch_addr",  32'(last_addr), 32'h010);

    // Two wait states per access: sw/lw round trip and latency.
    #2 reset = 1'b1;
    clear_mem();
    wait_cycles = 2;
    mem[0] = 32'h3401_1234;
    mem[1] = 32'h0800_0C10;
    mem[2] = 32'hDEAD_BEEF;
    for (int i = 0; i < 8; i++) mem[16 + i] = P2[i];
    push_wr(12'h008, 32'hA5A5_5A5A);
    push_wr(12'h100, 32'hA5A5_5A5A);
    push_wr(12'h104, 32'h0000_0000);
    @(negedge clk);
    reset = 1'b0;
    #1;
    wait_fetch(32'h0000_3048, 300, "p2_fetch_sw",   t0);
    @(negedge clk); #1;
    wait_fetch(32'h0000_304C, 50,  "p2_fetch_lw",   t1);
    @(negedge clk); #1;
    wait_fetch(32'h0000_3050, 50,  "p2_fetch_next", t2);
    check("p2_sw_cycles", 32'(t1 - t0), 32'd8);
    check("p2_lw_cycles", 32'(t2 - t1), 32'd9);
    wait_drain(200, "p2_drain");
    wait_state(ST_HALT, 100, "p2_illegal_halt");
    check("p2_halt_pc", pc_out, 32'h0000_3060);
    spurious_ack = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      check("halt_halted",  32'(halted),      32'd1);
      check("halt_state",   32'(dbg_state),   32'(ST_HALT));
      check("halt_mem_req", 32'(bus.mem_req), 32'd0);
    end
    spurious_ack = 1'b0;
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("halt_rst_pc",     pc_out,           RESET_PC);
    check("halt_rst_halted", 32'(halted),      32'd0);
    check("halt_rst_state",  32'(dbg_state),   32'(ST_RST));
    check("halt_rst_req",    32'(bus.mem_req), 32'd0);

    // Misaligned lw traps in EXEC without ever reaching MEM.
    clear_mem();
    wait_cycles = 0;
    mem[0] = 32'h8C05_0002;                      // lw $5,2($0)
    @(negedge clk);
    reset = 1'b0;
    mem_seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (dbg_state === ST_MEM) mem_seen++;
    end
    check("misalign_halted",   32'(halted),      32'd1);
    check("misalign_state",    32'(dbg_state),   32'(ST_HALT));
    check("misalign_no_mem",   32'(mem_seen),    32'd0);
    check("misalign_mem_req",  32'(bus.mem_req), 32'd0);
    check("misalign_pc",       pc_out,           32'h0000_3004);

    // Reset while a load is stalled in MEM abandons the access.
    #2 reset = 1'b1;
    clear_mem();
    mem[0] = 32'h3401_0077;                      // ori $1,$0,0x77
    mem[1] = 32'h8C01_0200;                      // lw $1,0x200($0), never acked
    block_en = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    wait_state(ST_MEM, 50, "midmem_reach");
    repeat (3) @(negedge clk);
    #1;
    check("midmem_addr",    32'(bus.mem_addr), 32'h200);
    check("midmem_req_hold", 32'(bus.mem_req), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("midmem_req_drop", 32'(bus.mem_req), 32'd0);
    check("midmem_state",    32'(dbg_state),   32'(ST_RST));
    check("midmem_pc",       pc_out,           RESET_PC);
    mem[0] = 32'hAC01_0104;                      // sw $1,0x104($0)
    mem[1] = 32'hFC00_0000;
    push_wr(12'h104, 32'h0000_0000);
    @(negedge clk);
    reset = 1'b0;
    #1;
    @(negedge clk); #1;
    check("midmem_refetch_addr", 32'(bus.mem_addr), 32'h000);
    wait_drain(50, "midmem_drain");
    wait_state(ST_HALT, 50, "midmem_final_halt");

    check("sb_final_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
